// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset sequencer with async assert, synchronized release, hold stretch
// and staggered per-output release, restartable by a synchronous soft reset.
module rst_seq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 4,
    parameter int STAGGER     = 4
) (
    input  logic               axi_aclk,
    input  logic               axi_resetn,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               rst_done_o,
    output logic               busy_o
);
    localparam int MAXC = HOLD_CYCLES > STAGGER ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic               sync_rst_n;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NUM_OUT-1:0] rel, rel_nxt, rel_step;
    logic               hold_tc, stag_tc;

    assign sync_rst_n = sync[SYNC_STAGES-1];
    // Releasing one more bit is a thermometer shift-in, so order is structural.
    assign rel_step   = (rel << 1) | NUM_OUT'(1);
    assign hold_tc    = state == S_HOLD && sync_rst_n && cnt == CW'(HOLD_CYCLES - 1);
    assign stag_tc    = state == S_RELEASE && cnt == CW'(STAGGER - 1);

    always_ff @(posedge axi_aclk or negedge axi_resetn)
        if (!axi_resetn) sync <= '0;
        else             sync <= {sync[SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge axi_aclk or negedge axi_resetn)
        if (!axi_resetn) begin
            state <= S_HOLD;
            cnt   <= '0;
            rel   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rel   <= rel_nxt;
        end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rel_nxt   = rel;
        if (soft_rst_req) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
            rel_nxt   = '0;
        end else if (hold_tc || stag_tc) begin
            rel_nxt   = rel_step;
            cnt_nxt   = '0;
            state_nxt = rel_step[NUM_OUT-1] ? S_DONE : S_RELEASE;
        end else if ((state == S_HOLD && sync_rst_n) || state == S_RELEASE) begin
            cnt_nxt   = (cnt == CW'(MAXC)) ? cnt : cnt + 1'b1;
        end
    end

    always_comb begin
        rst_n_o    = rel;
        rst_done_o = state == S_DONE;
        busy_o     = state != S_DONE;
    end
endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: directed + randomized checks of two sequencer configurations
// against an edge-count model of when each output bit must be released.
module tb_rst_seq_sync;
    localparam int SS_A = 2, H_A = 16, N_A = 4, S_A = 4;
    localparam int SS_B = 3, H_B = 1,  N_B = 1, S_B = 1;
    localparam int BIG  = 1 << 30;

    logic           clk = 1'b0;
    logic           axi_resetn;
    logic           soft_rst_req;
    logic [N_A-1:0] rst_a;
    logic           done_a, busy_a;
    logic [N_B-1:0] rst_b;
    logic           done_b, busy_b;

    int cyc    = 0;
    int base_a = BIG;
    int base_b = BIG;
    int tests  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rst_seq_sync #(.SYNC_STAGES(SS_A), .HOLD_CYCLES(H_A), .NUM_OUT(N_A), .STAGGER(S_A)) dut_a (
        .axi_aclk(clk), .axi_resetn(axi_resetn), .soft_rst_req(soft_rst_req),
        .rst_n_o(rst_a), .rst_done_o(done_a), .busy_o(busy_a));

    rst_seq_sync #(.SYNC_STAGES(SS_B), .HOLD_CYCLES(H_B), .NUM_OUT(N_B), .STAGGER(S_B)) dut_b (
        .axi_aclk(clk), .axi_resetn(axi_resetn), .soft_rst_req(soft_rst_req),
        .rst_n_o(rst_b), .rst_done_o(done_b), .busy_o(busy_b));

    // Bits released so far: bit 0 at edge base, then one more every stg edges.
    function automatic int rel_cnt(int base, int stg, int n);
        int k;
        if (cyc < base) return 0;
        k = (cyc - base) / stg + 1;
        return k > n ? n : k;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int ka, kb;
        ka = rel_cnt(base_a, S_A, N_A);
        kb = rel_cnt(base_b, S_B, N_B);
        chk({tag, ".a.rst"},  32'(rst_a),  (32'd1 << ka) - 1);
        chk({tag, ".a.done"}, 32'(done_a), 32'(ka == N_A));
        chk({tag, ".a.busy"}, 32'(busy_a), 32'(ka != N_A));
        chk({tag, ".b.rst"},  32'(rst_b),  (32'd1 << kb) - 1);
        chk({tag, ".b.done"}, 32'(done_b), 32'(kb == N_B));
        chk({tag, ".b.busy"}, 32'(busy_b), 32'(kb != N_B));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        cyc++;
        if (axi_resetn && soft_rst_req) begin
            base_a = base_a > cyc + H_A ? base_a : cyc + H_A;
            base_b = base_b > cyc + H_B ? base_b : cyc + H_B;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic assert_rst();
        axi_resetn = 1'b0;
        base_a = BIG;
        base_b = BIG;
    endtask

    // Rise lands between edges cyc and cyc+1, so edge 1 is cyc+1.
    task automatic release_rst();
        axi_resetn = 1'b1;
        base_a = cyc + SS_A + H_A;
        base_b = cyc + SS_B + H_B;
    endtask

    task automatic async_pulse(int w);
        #1 assert_rst();
        #1 check_all("pulse_low");
        #(w) release_rst();
    endtask

    initial begin
        soft_rst_req = 1'b0;
        assert_rst();
        #1 check_all("por");
        repeat (5) tick("por_hold");
        release_rst();
        repeat (32) tick("power_on");
        release_rst();
        assert_rst();
        repeat (2) tick("rst_again");
        release_rst();
        repeat (24) tick("pre_mid");
        async_pulse(2);
        repeat (32) tick("mid_async");
        soft_rst_req = 1'b1;
        tick("soft_done");
        soft_rst_req = 1'b0;
        repeat (32) tick("after_soft");
        soft_rst_req = 1'b1;
        tick("soft_start");
        soft_rst_req = 1'b0;
        repeat (20) tick("to_release");
        soft_rst_req = 1'b1;
        repeat (10) tick("soft_held");
        soft_rst_req = 1'b0;
        while (cyc < base_a - 1) tick("to_tc");
        soft_rst_req = 1'b1;
        #3 assert_rst();
        #1 check_all("coinc_low");
        tick("coinc_edge");
        release_rst();
        soft_rst_req = 1'b0;
        repeat (32) tick("after_coinc");
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                async_pulse($urandom_range(0, 2));
                tick("rnd_pulse");
            end else if (r == 1) begin
                assert_rst();
                repeat ($urandom_range(1, 4)) tick("rnd_rst");
                release_rst();
            end else if (r < 4) begin
                soft_rst_req = 1'b1;
                repeat ($urandom_range(1, 3)) tick("rnd_soft");
                soft_rst_req = 1'b0;
            end else begin
                repeat ($urandom_range(1, 6)) tick("rnd_run");
            end
        end
        repeat (32) tick("drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
